pipeline_stall_controller: RTL and testbench

Central sequencer for the 5-stage pipeline's stall and flush controls. It takes three inputs: the combinational load-use stall from the hazard detection unit, the branch/jump redirect from EX, and the data-memory handshake. It arbitrates between them by priority, applies multi-cycle redirect bubbles and memory wait-state freezes, and drives every pipeline-register enable and flush. It also keeps stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/event_counter.sv | 19 +
 rtl/pipeline_stall_controller.sv | 137 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller and stage registers.
package pipeline_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT  = 32;
  localparam int unsigned REDIRECT_CNT_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/event_counter.sv
// Wrapping event counter with synchronous active-high clear.
module event_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Arbitrates memory freeze, redirect and load-use stall into pipeline register
// enables/flushes; keeps stall/flush counters and a sticky memory-timeout flag.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_CYCLES = 1,
  parameter int unsigned MAX_WAIT        = 64,
  parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_stall,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  pipe_state_e               state_q, state_d;
  pipe_state_e               ret_q, ret_d;
  pipe_state_e               eff_state;
  logic [REDIRECT_CNT_W-1:0] rcnt_q, rcnt_d;
  logic [WAIT_W-1:0]         wait_q;
  logic                      mem_busy;
  logic                      flush_inc;
  logic                      stall_inc;

  assign mem_busy  = dmem_req & ~dmem_ready;
  // Leaving MEM_WAIT, the cycle is judged as if we were already back in the return state.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  // Next-state and control decode, highest priority first.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    rcnt_d       = rcnt_q;
    flush_inc    = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mem_busy) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      if (state_q != MEM_WAIT) begin
        ret_d   = state_q;
        state_d = MEM_WAIT;
      end
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_inc   = 1'b1;
      if (REDIRECT_CYCLES > 0) begin
        rcnt_d  = REDIRECT_CNT_W'(REDIRECT_CYCLES);
        state_d = REDIRECT;
      end else begin
        state_d = RUN;
      end
    end else if (eff_state == REDIRECT) begin
      if_id_flush = 1'b1;
      rcnt_d      = rcnt_q - REDIRECT_CNT_W'(1);
      state_d     = (rcnt_q <= REDIRECT_CNT_W'(1)) ? RUN : REDIRECT;
    end else begin
      state_d = RUN;
      if (load_use_stall) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  // State, redirect counter, wait counter and timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      rcnt_q      <= '0;
      wait_q      <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rcnt_q  <= rcnt_d;
      if (mem_busy) begin
        if (wait_q < WAIT_W'(MAX_WAIT)) begin
          wait_q <= wait_q + WAIT_W'(1);
        end
        if (wait_q >= WAIT_W'(MAX_WAIT - 1)) begin
          mem_timeout <= 1'b1;
        end
      end else begin
        wait_q <= '0;
      end
    end
  end

  assign stall_inc = ~rst & ~pc_en;

  event_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  event_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed vector table, corner-case sequences and random stimulus vs. a reference model.
module tb_pipeline_stall_controller;

  localparam int unsigned RC = 2;
  localparam int unsigned MW = 8;
  localparam int unsigned CW = 8;

  // ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [6:0] C_RST  = 7'b0111111;
  localparam logic [6:0] C_RUN  = 7'b1101010;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_BUB  = 7'b1111010;
  localparam logic [6:0] C_BUSY = 7'b0000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, load_use_stall, branch_taken, dmem_req, dmem_ready;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic [CW-1:0] stall_count, flush_count;
  logic          mem_timeout;

  pipeline_stall_controller #(
    .REDIRECT_CYCLES (RC),
    .MAX_WAIT        (MW),
    .CNT_W           (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_use_stall (load_use_stall),
    .branch_taken   (branch_taken),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_en       (id_ex_en),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_flush   (mem_wb_flush),
    .stall_count    (stall_count),
    .flush_count    (flush_count),
    .mem_timeout    (mem_timeout)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: bubbles still owed, consecutive busy cycles, counters.
  int m_bubbles, m_wait, m_sc, m_fc;
  bit m_to;

  logic [6:0]    s_ctrl;
  logic [CW-1:0] s_sc, s_fc;
  logic          s_to;

  typedef struct {
    logic       r, lu, br, req, rdy;
    logic [6:0] ctrl;
    int         sc, fc;
    logic       to;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [6:0] model_ctrl(input logic r, lu, br, req, rdy);
    if (r)                return C_RST;
    if (req && !rdy)      return C_BUSY;
    if (br)               return C_BR;
    if (m_bubbles > 0)    return C_BUB;
    if (lu)               return C_LU;
    return C_RUN;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, lu, br, req, rdy);
    logic [6:0] e;
    @(negedge clk);
    rst = r; load_use_stall = lu; branch_taken = br; dmem_req = req; dmem_ready = rdy;
    #1;
    s_ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
    s_sc = stall_count; s_fc = flush_count; s_to = mem_timeout;
    e = model_ctrl(r, lu, br, req, rdy);
    check("model_ctrl", 32'(s_ctrl), 32'(e));
    check("model_stall_count", 32'(s_sc), 32'(m_sc));
    check("model_flush_count", 32'(s_fc), 32'(m_fc));
    check("model_mem_timeout", 32'(s_to), 32'(m_to));
    // Advance the model to the state after the coming rising edge.
    if (r) begin
      m_bubbles = 0; m_wait = 0; m_sc = 0; m_fc = 0; m_to = 1'b0;
    end else begin
      if (req && !rdy) begin
        if (m_wait < int'(MW)) m_wait++;
        if (m_wait == int'(MW)) m_to = 1'b1;
      end else begin
        m_wait = 0;
        if (br) begin
          m_bubbles = RC;
          m_fc = (m_fc + 1) % (1 << CW);
        end else if (m_bubbles > 0) begin
          m_bubbles--;
        end
      end
      if (!e[6]) m_sc = (m_sc + 1) % (1 << CW);
    end
  endtask

  initial begin
    logic [CW-1:0] sc0;
    logic          phase;
    rst = 1'b1; load_use_stall = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    m_bubbles = 0; m_wait = 0; m_sc = 0; m_fc = 0; m_to = 1'b0;
    @(posedge clk);

    //            r     lu    br    req   rdy   ctrl    sc fc to
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RST,  0, 0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,  0, 0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   0, 0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,  1, 0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, C_BR,   1, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB,  1, 1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_BUB,  1, 1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,  1, 1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   1, 1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,  2, 1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_BUSY, 2, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,  3, 1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR,   3, 1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB,  3, 2, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_BUB,  3, 2, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN,  3, 2, 1'b0};

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].r, tbl[i].lu, tbl[i].br, tbl[i].req, tbl[i].rdy);
      check($sformatf("tbl%0d_ctrl", i), 32'(s_ctrl), 32'(tbl[i].ctrl));
      check($sformatf("tbl%0d_stall_count", i), 32'(s_sc), 32'(tbl[i].sc));
      check($sformatf("tbl%0d_flush_count", i), 32'(s_fc), 32'(tbl[i].fc));
      check($sformatf("tbl%0d_mem_timeout", i), 32'(s_to), 32'(tbl[i].to));
    end

    // Memory freeze while one redirect bubble is still owed.
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("redir_first_bubble", 32'(s_ctrl), 32'(C_BUB));
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 1, 1, 0);
      if (k == 0) sc0 = s_sc;
      check($sformatf("redir_frozen%0d", k), 32'(s_ctrl), 32'(C_BUSY));
    end
    cycle(0, 0, 0, 1, 1);
    check("redir_last_bubble", 32'(s_ctrl), 32'(C_BUB));
    check("redir_stall_delta", 32'(CW'(s_sc - sc0)), 32'd4);
    cycle(0, 0, 0, 0, 0);
    check("redir_back_to_run", 32'(s_ctrl), 32'(C_RUN));

    // Timeout after MW consecutive busy cycles, sticky until reset.
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 1, 0);
      if (k == 7) check("timeout_before", 32'(s_to), 32'd0);
      if (k == 8) check("timeout_set", 32'(s_to), 32'd1);
    end
    cycle(0, 0, 0, 1, 1);
    check("timeout_sticky_ready", 32'(s_to), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("timeout_sticky_idle", 32'(s_to), 32'd1);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("timeout_cleared", 32'(s_to), 32'd0);

    // Reset in the middle of a redirect.
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("rstmid_bubble", 32'(s_ctrl), 32'(C_BUB));
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("rstmid_ctrl", 32'(s_ctrl), 32'(C_RUN));
    check("rstmid_stall_count", 32'(s_sc), 32'd0);
    check("rstmid_flush_count", 32'(s_fc), 32'd0);

    // Stall counter wrap.
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 255; k++) cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("wrap_max", 32'(s_sc), 32'd255);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    check("wrap_zero", 32'(s_sc), 32'd0);

    // Random stimulus, alternating phases of mostly-ready and mostly-stalled memory.
    for (int i = 0; i < 3000; i++) begin
      phase = ((i / 200) % 2) == 1;
      cycle(($urandom % 64) == 0,
            ($urandom % 4) == 0,
            ($urandom % 6) == 0,
            phase ? (($urandom % 8) != 0) : (($urandom % 3) == 0),
            phase ? (($urandom % 12) == 0) : (($urandom % 4) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
